rx_frame_checker: RTL and testbench
===================================

// Module: rx_frame_checker
// PURPOSE
//  Serial UART Rx frame checker; a parametrised successor to the per-frame parity check.
//  Accumulates parity bit-by-bit as sampled bits arrive and assembles data LSB-first.
//  Checks the parity bit (odd/even/mark/space) and the stop bit, and flags errors.
//  Keeps saturating error counters. Sits between the Rx sampler/edge counter and the Rx FSM/output register.
// PARAMETERS
//  MAX_WIDTH  8   maximum data bits per frame (runtime length DATA_LEN <= MAX_WIDTH)
//  LEN_W      4   width of DATA_LEN; must hold MAX_WIDTH
//  CNT_W      8   width of each saturating error counter
// PORTS
//  CLK          in   1          clock
//  RST          in   1          synchronous reset, active-high
//  frm_start    in   1          start bit confirmed; begins a frame, latches config
//  bit_vld      in   1          one-cycle strobe: sampled_bit holds the next serial bit
//  sampled_bit  in   1          majority-sampled serial bit
//  PAR_EN       in   1          parity bit present in frame (latched at frm_start)
//  PAR_MODE     in   2          00 even, 01 odd, 10 mark(1), 11 space(0) (latched)
//  DATA_LEN     in   LEN_W      data bits per frame (latched); 0 or >MAX_WIDTH -> MAX_WIDTH
//  err_clr      in   1          clears both counters and sticky flags
//  P_DATA       out  MAX_WIDTH  received data, right-aligned, unused MSBs 0
//  data_vld     out  1          one-cycle pulse: frame complete and error-free
//  frm_done     out  1          one-cycle pulse: frame complete (with or without errors)
//  par_err      out  1          parity error of last frame, valid with frm_done, held until next frm_done
//  stp_err      out  1          stop-bit error of last frame, same timing as par_err
//  par_err_cnt  out  CNT_W      saturating count of parity errors
//  stp_err_cnt  out  CNT_W      saturating count of stop errors
//  busy         out  1          frame in progress (state != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; latched config cleared to even/len MAX_WIDTH/no parity.
//  FSM: IDLE -> DATA on frm_start. DATA: on each bit_vld, write bit to P_DATA[idx] and par_acc ^= bit,
//   idx++. After the DATA_LEN-th bit: -> PARITY if PAR_EN, else -> STOP.
//  PARITY: on bit_vld, compute par_err_nxt. Expected bit: even = par_acc, odd = ~par_acc,
//   mark = 1, space = 0. par_err_nxt = (bit != expected). -> STOP.
//  STOP: on bit_vld, stp_err_nxt = ~bit. -> IDLE, in the same cycle pulse frm_done and register
//   par_err/stp_err. data_vld = frm_done & ~par_err & ~stp_err.
//  Latency: frm_done/data_vld/flags assert on the clock edge that samples the stop-bit bit_vld (1 cycle).
//  P_DATA: cleared to 0 at frm_start; stable from frm_done until the next frm_start.
//  bit_vld in IDLE: ignored. frm_start while busy: current frame aborted (no frm_done, counters
//   untouched), new frame restarts from DATA with freshly latched config.
//  frm_start and bit_vld in the same cycle: frm_start wins; that bit is ignored.
//  PAR_EN=0: par_err is forced 0 for that frame.
//  Counters: +1 on frm_done when the matching flag is set; hold at 2^CNT_W-1 (no wrap).
//  err_clr: zeroes both counters, par_err and stp_err next edge; if coincident with frm_done, the
//   clear wins (the frame's errors are not counted); frm_done/data_vld still pulse.
//  Config inputs changing mid-frame have no effect until the next frm_start.
//  RST mid-frame: synchronous return to IDLE, all outputs 0, no pulses.
// TESTING
//  8N1, even, data 0xA5: bits 1,0,1,0,0,1,0,1 + stop 1 -> P_DATA=0xA5, data_vld=1, errs 0.
//  8E1 0xA5 (4 ones), parity bit 1 -> par_err=1, par_err_cnt=1, data_vld=0; with parity 0 -> clean.
//  7O1, DATA_LEN=7, 0x35 (4 ones), parity bit 1 -> clean; stop bit 0 -> stp_err=1, stp_err_cnt=1.
//  Mark mode, parity bit 0 -> par_err=1; space mode, parity bit 0 -> clean.
//  CNT_W=2: 5 parity-error frames -> par_err_cnt stays 3; err_clr -> 0; err_clr with frm_done -> 0.
//  frm_start after 3 data bits -> no frm_done; next full frame 0x3C reported correctly.
//  RST asserted mid-frame -> busy=0 next cycle, all outputs 0.

Source files
------------

// File: rtl/rx_frame_checker.sv
// rtl/rx_frame_checker.sv - UART Rx frame checker: LSB-first data assembly, parity/stop check, error counters
module rx_frame_checker #(
  parameter int MAX_WIDTH = 8,
  parameter int LEN_W     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 frm_start,
  input  logic                 bit_vld,
  input  logic                 sampled_bit,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_MODE,
  input  logic [LEN_W-1:0]     DATA_LEN,
  input  logic                 err_clr,
  output logic [MAX_WIDTH-1:0] P_DATA,
  output logic                 data_vld,
  output logic                 frm_done,
  output logic                 par_err,
  output logic                 stp_err,
  output logic [CNT_W-1:0]     par_err_cnt,
  output logic [CNT_W-1:0]     stp_err_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(MAX_WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] r_len;
  logic             r_par_en;
  logic [1:0]       r_par_mode;
  logic             r_par_acc;
  logic             r_par_bad;
  logic [LEN_W-1:0] w_len_cfg;
  logic             w_last_bit;
  logic             w_exp_par;
  logic             w_stop_take;
  logic             w_par_flag;
  logic             w_stp_flag;

  assign w_len_cfg   = (DATA_LEN == '0 || DATA_LEN > LP_MAX_LEN) ? LP_MAX_LEN : DATA_LEN;
  assign w_last_bit  = (r_idx + LEN_W'(1)) == r_len;
  assign w_stop_take = (r_state == S_STOP) && bit_vld && !frm_start;
  assign w_par_flag  = r_par_en & r_par_bad;
  assign w_stp_flag  = ~sampled_bit;
  assign busy        = (r_state != S_IDLE);
  assign data_vld    = frm_done & ~par_err & ~stp_err;

  always_comb begin
    w_exp_par = 1'b0;
    case (r_par_mode)
      2'b00:   w_exp_par = r_par_acc;
      2'b01:   w_exp_par = ~r_par_acc;
      2'b10:   w_exp_par = 1'b1;
      default: w_exp_par = 1'b0;
    endcase
  end

  // frm_start overrides every state, which is also how an in-flight frame gets aborted
  always_comb begin
    w_state_nxt = r_state;
    if (frm_start) begin
      w_state_nxt = S_DATA;
    end else begin
      case (r_state)
        S_DATA:   if (bit_vld && w_last_bit) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
        S_PARITY: if (bit_vld) w_state_nxt = S_STOP;
        S_STOP:   if (bit_vld) w_state_nxt = S_IDLE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx       <= '0;
      r_len       <= LP_MAX_LEN;
      r_par_en    <= 1'b0;
      r_par_mode  <= 2'b00;
      r_par_acc   <= 1'b0;
      r_par_bad   <= 1'b0;
      P_DATA      <= '0;
      frm_done    <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else begin
      frm_done <= w_stop_take;
      if (frm_start) begin
        r_idx      <= '0;
        r_len      <= w_len_cfg;
        r_par_en   <= PAR_EN;
        r_par_mode <= PAR_MODE;
        r_par_acc  <= 1'b0;
        r_par_bad  <= 1'b0;
        P_DATA     <= '0;
      end else if (bit_vld) begin
        if (r_state == S_DATA) begin
          for (int i = 0; i < MAX_WIDTH; i++) begin
            if (r_idx == LEN_W'(i)) P_DATA[i] <= sampled_bit;
          end
          r_par_acc <= r_par_acc ^ sampled_bit;
          r_idx     <= r_idx + LEN_W'(1);
        end else if (r_state == S_PARITY) begin
          r_par_bad <= (sampled_bit != w_exp_par);
        end
      end
      // a coincident clear drops the finishing frame's errors entirely
      if (err_clr) begin
        par_err     <= 1'b0;
        stp_err     <= 1'b0;
        par_err_cnt <= '0;
        stp_err_cnt <= '0;
      end else if (w_stop_take) begin
        par_err <= w_par_flag;
        stp_err <= w_stp_flag;
        if (w_par_flag && par_err_cnt != '1) par_err_cnt <= par_err_cnt + CNT_W'(1);
        if (w_stp_flag && stp_err_cnt != '1) stp_err_cnt <= stp_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_checker.sv
// tb/tb_rx_frame_checker.sv - bench for rx_frame_checker: frame-level model, per-cycle compare, directed frames
module tb_rx_frame_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       frm_start = 1'b0;
  logic       bit_vld = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       PAR_EN = 1'b0;
  logic [1:0] PAR_MODE = 2'b00;
  logic [3:0] DATA_LEN = 4'd8;
  logic       err_clr = 1'b0;
  logic [7:0] P_DATA;
  logic       data_vld, frm_done, par_err, stp_err, busy;
  logic [1:0] par_err_cnt, stp_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  rx_frame_checker #(.MAX_WIDTH(8), .LEN_W(4), .CNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .frm_start(frm_start), .bit_vld(bit_vld),
    .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE),
    .DATA_LEN(DATA_LEN), .err_clr(err_clr), .P_DATA(P_DATA),
    .data_vld(data_vld), .frm_done(frm_done), .par_err(par_err),
    .stp_err(stp_err), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect the bits of the current frame, judge the frame once all have arrived
  bit       m_active = 0;
  int       m_len = 8;
  bit       m_pen = 0;
  bit [1:0] m_mode = 0;
  bit       m_bits[$];
  bit [7:0] m_pdata = 0;
  bit       m_done = 0, m_pe = 0, m_se = 0;
  int       m_pcnt = 0, m_scnt = 0;

  always @(posedge CLK) begin
    bit fpe, fse, pbit, want;
    m_done = 0;
    if (RST) begin
      m_active = 0; m_bits.delete(); m_pdata = 0; m_pe = 0; m_se = 0;
      m_pcnt = 0; m_scnt = 0; m_len = 8; m_pen = 0; m_mode = 0;
    end else begin
      fpe = 0; fse = 0;
      if (frm_start) begin
        m_active = 1; m_bits.delete(); m_pdata = 0;
        m_len  = (DATA_LEN == 0 || DATA_LEN > 8) ? 8 : int'(DATA_LEN);
        m_pen  = PAR_EN;
        m_mode = PAR_MODE;
      end else if (bit_vld && m_active) begin
        m_bits.push_back(sampled_bit);
        if (m_bits.size() <= m_len) m_pdata[m_bits.size()-1] = sampled_bit;
        if (m_bits.size() == m_len + int'(m_pen) + 1) begin
          m_active = 0;
          m_done = 1;
          if (m_pen) begin
            pbit = m_bits[m_len];
            case (m_mode)
              2'd0: want = ($countones(m_pdata) % 2) == 1;
              2'd1: want = ($countones(m_pdata) % 2) == 0;
              2'd2: want = 1;
              default: want = 0;
            endcase
            fpe = (pbit != want);
          end
          fse = (m_bits[m_bits.size()-1] == 0);
        end
      end
      if (err_clr) begin
        m_pe = 0; m_se = 0; m_pcnt = 0; m_scnt = 0;
      end else if (m_done) begin
        m_pe = fpe; m_se = fse;
        if (fpe) m_pcnt = (m_pcnt == 3) ? 3 : m_pcnt + 1;
        if (fse) m_scnt = (m_scnt == 3) ? 3 : m_scnt + 1;
      end
    end
  end

  always @(posedge CLK) begin
    #2;
    chk("p_data",   P_DATA,      m_pdata);
    chk("frm_done", frm_done,    m_done);
    chk("data_vld", data_vld,    m_done & ~m_pe & ~m_se);
    chk("par_err",  par_err,     m_pe);
    chk("stp_err",  stp_err,     m_se);
    chk("par_cnt",  par_err_cnt, m_pcnt);
    chk("stp_cnt",  stp_err_cnt, m_scnt);
    chk("busy",     busy,        m_active);
  end

  task automatic send_bit(input bit b, input bit clr);
    @(negedge CLK);
    bit_vld = 1; sampled_bit = b; err_clr = clr;
    @(negedge CLK);
    bit_vld = 0; err_clr = 0; sampled_bit = ~b;
  endtask

  task automatic start_frame(input bit [3:0] len_cfg, input bit pen, input bit [1:0] mode, input bit with_bit);
    @(negedge CLK);
    frm_start = 1; DATA_LEN = len_cfg; PAR_EN = pen; PAR_MODE = mode;
    bit_vld = with_bit; sampled_bit = 1;
    @(negedge CLK);
    frm_start = 0; bit_vld = 0;
    DATA_LEN = 4'd3; PAR_EN = ~pen; PAR_MODE = ~mode;
  endtask

  task automatic send_frame(input bit [7:0] data, input bit [3:0] len_cfg, input bit pen,
                            input bit [1:0] mode, input bit pbit, input bit sbit,
                            input bit clr_at_stop, input bit with_bit);
    int n;
    n = (len_cfg == 0 || len_cfg > 8) ? 8 : int'(len_cfg);
    start_frame(len_cfg, pen, mode, with_bit);
    for (int i = 0; i < n; i++) send_bit(data[i], 0);
    if (pen) send_bit(pbit, 0);
    send_bit(sbit, clr_at_stop);
  endtask

  task automatic chk_frame(input string tag, input bit [7:0] pd, input bit vld, input bit pe,
                           input bit se, input int pc, input int sc);
    chk({tag, ".done"}, frm_done, 1'b1);
    chk({tag, ".pdata"}, P_DATA, pd);
    chk({tag, ".vld"}, data_vld, vld);
    chk({tag, ".pe"}, par_err, pe);
    chk({tag, ".se"}, stp_err, se);
    chk({tag, ".pcnt"}, par_err_cnt, pc);
    chk({tag, ".scnt"}, stp_err_cnt, sc);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst.busy", busy, 0);
    chk("rst.pdata", P_DATA, 0);
    chk("rst.done", frm_done, 0);
    RST = 0;
    send_bit(1, 0);
    send_bit(0, 0);
    send_frame(8'hA5, 8, 0, 2'd0, 0, 1, 0, 0);
    chk_frame("8n1", 8'hA5, 1, 0, 0, 0, 0);
    send_frame(8'hA5, 8, 1, 2'd0, 1, 1, 0, 0);
    chk_frame("8e1_bad", 8'hA5, 0, 1, 0, 1, 0);
    send_frame(8'hA5, 8, 1, 2'd0, 0, 1, 0, 0);
    chk_frame("8e1_ok", 8'hA5, 1, 0, 0, 1, 0);
    send_frame(8'hB5, 7, 1, 2'd1, 1, 1, 0, 0);
    chk_frame("7o1_ok", 8'h35, 1, 0, 0, 1, 0);
    send_frame(8'h35, 7, 1, 2'd1, 1, 0, 0, 0);
    chk_frame("7o1_stp", 8'h35, 0, 0, 1, 1, 1);
    send_frame(8'h00, 8, 1, 2'd2, 0, 1, 0, 0);
    chk_frame("mark", 8'h00, 0, 1, 0, 2, 1);
    send_frame(8'hFF, 8, 1, 2'd3, 0, 1, 0, 0);
    chk_frame("space", 8'hFF, 1, 0, 0, 2, 1);
    for (int k = 0; k < 3; k++) send_frame(8'hA5, 8, 1, 2'd0, 1, 1, 0, 0);
    chk_frame("sat", 8'hA5, 0, 1, 0, 3, 1);
    @(negedge CLK); err_clr = 1;
    @(negedge CLK); err_clr = 0;
    chk("clr.pcnt", par_err_cnt, 0);
    chk("clr.scnt", stp_err_cnt, 0);
    chk("clr.pe", par_err, 0);
    send_frame(8'h55, 8, 1, 2'd0, 1, 0, 1, 0);
    chk_frame("clr_done", 8'h55, 1, 0, 0, 0, 0);
    start_frame(8, 0, 2'd0, 0);
    for (int i = 0; i < 3; i++) send_bit(1, 0);
    send_frame(8'h3C, 8, 0, 2'd0, 0, 1, 0, 1);
    chk_frame("abort", 8'h3C, 1, 0, 0, 0, 0);
    send_frame(8'h81, 0, 0, 2'd0, 0, 1, 0, 0);
    chk_frame("len0", 8'h81, 1, 0, 0, 0, 0);
    send_frame(8'h7E, 12, 0, 2'd0, 0, 1, 0, 0);
    chk_frame("len12", 8'h7E, 1, 0, 0, 0, 0);
    send_frame(8'hA5, 8, 1, 2'd0, 1, 1, 0, 0);
    chk_frame("pre_rst", 8'hA5, 0, 1, 0, 1, 0);
    start_frame(8, 1, 2'd0, 0);
    for (int i = 0; i < 4; i++) send_bit(1, 0);
    @(negedge CLK); RST = 1;
    @(negedge CLK); RST = 0;
    chk("mid_rst.busy", busy, 0);
    chk("mid_rst.pdata", P_DATA, 0);
    chk("mid_rst.pcnt", par_err_cnt, 0);
    chk("mid_rst.pe", par_err, 0);
    send_frame(8'hC3, 8, 0, 2'd0, 0, 1, 0, 0);
    chk_frame("post_rst", 8'hC3, 1, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
